// File: rtl/systolic_mm_ctrl.sv
// systolic_mm_ctrl: sequencer for an NxN output-stationary systolic multiplier.
// Buffers A and B, clears the array, streams skewed operands, then latches C.
// Ports:
//   clk, reset             clock, async active-high reset
//   ld_valid/ld_ready      operand write handshake (ld_sel, ld_row, ld_col, ld_data)
//   start, busy, done      operation control and status
//   arr_clear, arr_a/b     MAC array clear and west/north edge feeds
//   arr_sum                array accumulators, row-major
//   out_matrix, out_valid  latched product C, row-major
module systolic_mm_ctrl #(
    parameter int MATRIX_SIZE = 3,
    parameter int DATA_SIZE   = 8,
    localparam int IW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              ld_valid,
    input  logic                                              ld_sel,
    input  logic [IW-1:0]                                     ld_row,
    input  logic [IW-1:0]                                     ld_col,
    input  logic [DATA_SIZE-1:0]                              ld_data,
    output logic                                              ld_ready,
    input  logic                                              start,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              arr_clear,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]             arr_a,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]             arr_b,
    input  logic [MATRIX_SIZE*MATRIX_SIZE-1:0][DATA_SIZE-1:0] arr_sum,
    output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_matrix,
    output logic                                              out_valid
);

    localparam int N  = MATRIX_SIZE;
    localparam int TW = $clog2(3 * N - 1);

    localparam logic [TW-1:0] T_FEED_END  = TW'(2 * N - 2);
    localparam logic [TW-1:0] T_DRAIN_END = TW'(3 * N - 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    typedef logic [N-1:0][DATA_SIZE-1:0] edge_t;

    state_t              state;
    logic [TW-1:0]       t;
    logic [DATA_SIZE-1:0] a_buf [N][N];
    logic [DATA_SIZE-1:0] b_buf [N][N];
    logic                load_ok;

    assign ld_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign load_ok  = ld_valid && (int'(ld_row) < N) && (int'(ld_col) < N);

    // Row i of A enters i cycles late so A[i][k] meets B[k][j] at PE(i,j).
    function automatic edge_t skew_a(input logic [TW-1:0] tt);
        edge_t v;
        int    k;
        v = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(tt) - i;
            if (k >= 0 && k < N) v[i] = a_buf[i][k[IW-1:0]];
        end
        return v;
    endfunction

    function automatic edge_t skew_b(input logic [TW-1:0] tt);
        edge_t v;
        int    k;
        v = '0;
        for (int j = 0; j < N; j++) begin
            k = int'(tt) - j;
            if (k >= 0 && k < N) v[j] = b_buf[k[IW-1:0]][j];
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            t          <= '0;
            done       <= 1'b0;
            arr_clear  <= 1'b0;
            arr_a      <= '0;
            arr_b      <= '0;
            out_matrix <= '0;
            out_valid  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf[i][j] <= '0;
                    b_buf[i][j] <= '0;
                end
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load_ok) begin
                        if (ld_sel) b_buf[ld_row][ld_col] <= ld_data;
                        else        a_buf[ld_row][ld_col] <= ld_data;
                    end
                    if (start) begin
                        state     <= S_CLEAR;
                        arr_clear <= 1'b1;
                        arr_a     <= '0;
                        arr_b     <= '0;
                        out_valid <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    // Buffers already hold any write accepted with start.
                    state     <= S_FEED;
                    t         <= '0;
                    arr_clear <= 1'b0;
                    arr_a     <= skew_a('0);
                    arr_b     <= skew_b('0);
                end
                S_FEED: begin
                    t <= t + TW'(1);
                    if (t == T_FEED_END) begin
                        state <= S_DRAIN;
                        arr_a <= '0;
                        arr_b <= '0;
                    end else begin
                        arr_a <= skew_a(t + TW'(1));
                        arr_b <= skew_b(t + TW'(1));
                    end
                end
                S_DRAIN: begin
                    t <= t + TW'(1);
                    if (t == T_DRAIN_END) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    out_matrix <= arr_sum;
                    out_valid  <= 1'b1;
                    done       <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    t     <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// tb_systolic_mm_ctrl: bench for systolic_mm_ctrl with a 3x3 MAC array model.
// Directed operand sets; expected products are queued and checked on done.
module tb_systolic_mm_ctrl;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int IW = $clog2(N);

    typedef logic [N*N-1:0][DW-1:0] mat_t;

    logic                   clk;
    logic                   reset;
    logic                   ld_valid;
    logic                   ld_sel;
    logic [IW-1:0]          ld_row;
    logic [IW-1:0]          ld_col;
    logic [DW-1:0]          ld_data;
    logic                   ld_ready;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   arr_clear;
    logic [N-1:0][DW-1:0]   arr_a;
    logic [N-1:0][DW-1:0]   arr_b;
    mat_t                   arr_sum;
    mat_t                   out_matrix;
    logic                   out_valid;

    systolic_mm_ctrl #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_sel     (ld_sel),
        .ld_row     (ld_row),
        .ld_col     (ld_col),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .arr_clear  (arr_clear),
        .arr_a      (arr_a),
        .arr_b      (arr_b),
        .arr_sum    (arr_sum),
        .out_matrix (out_matrix),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output-stationary MAC array; arr_clear acts as a synchronous clear.
    logic [DW-1:0] acc   [N][N];
    logic [DW-1:0] ar    [N][N];
    logic [DW-1:0] br    [N][N];
    logic [DW-1:0] west  [N][N];
    logic [DW-1:0] north [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            west[i][0]  = arr_a[i];
            north[0][i] = arr_b[i];
            for (int j = 0; j < N - 1; j++) begin
                west[i][j+1]  = ar[i][j];
                north[j+1][i] = br[j][i];
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_sum[i*N+j] = acc[i][j];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || arr_clear) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] + DW'(west[i][j] * north[i][j]);
                    ar[i][j]  <= west[i][j];
                    br[i][j]  <= north[i][j];
                end
        end
    end

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    int   done_cnt  = 0;
    logic prev_done = 1'b0;
    mat_t exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: each done pops one expected product.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_done) check("done_one_cycle", 128'(done), 128'(0));
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    mat_t e;
                    e = exp_q.pop_front();
                    check("out_matrix", 128'(out_matrix), 128'(e));
                    check("out_valid", 128'(out_valid), 128'(1));
                    check("done_latency", 128'(cyc - start_cyc + 1),
                          128'(3 * N + 1));
                end
            end
        end
        prev_done = reset ? 1'b0 : done;
    end

    function automatic mat_t fill(input int v);
        mat_t m;
        for (int i = 0; i < N * N; i++) m[i] = DW'(v);
        return m;
    endfunction

    task automatic wr(input logic s, input int r, input int c, input int d);
        ld_valid = 1'b1;
        ld_sel   = s;
        ld_row   = IW'(r);
        ld_col   = IW'(c);
        ld_data  = DW'(d);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic load(input logic s, input mat_t m);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                wr(s, i, j, int'(m[i*N+j]));
    endtask

    task automatic do_start(input mat_t e);
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done", name);
        end
        step();
    endtask

    mat_t b_m  = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    mat_t id_m = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    mat_t c6_m = {8'd18, 8'd14, 8'd10, 8'd6, 8'd5, 8'd4, 8'd15, 8'd12, 8'd9};

    initial begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_sel   = 1'b0;
        ld_row   = '0;
        ld_col   = '0;
        ld_data  = '0;
        start    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_clear", 128'(arr_clear), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_arr_a", 128'(arr_a), 128'(0));
        check("rst_arr_b", 128'(arr_b), 128'(0));
        check("rst_out_matrix", 128'(out_matrix), 128'(0));
        check("rst_ld_ready", 128'(ld_ready), 128'(1));

        // 1: identity times B
        load(1'b0, id_m);
        load(1'b1, b_m);
        do_start(b_m);
        wait_done("t1");

        // 2: all 2 times all 3, plus skew of row 2
        load(1'b0, fill(2));
        load(1'b1, fill(3));
        do_start(fill(18));
        check("t2_clear", 128'(arr_clear), 128'(1));
        check("t2_clear_a", 128'(arr_a), 128'(0));
        step();
        check("t2_a0_t0", 128'(arr_a[0]), 128'(2));
        check("t2_b0_t0", 128'(arr_b[0]), 128'(3));
        check("t2_a2_t0", 128'(arr_a[2]), 128'(0));
        step();
        check("t2_a2_t1", 128'(arr_a[2]), 128'(0));
        step();
        check("t2_a2_t2", 128'(arr_a[2]), 128'(2));
        wait_done("t2");

        // 3: same operands again, started in the IDLE cycle after DONE
        do_start(fill(18));
        check("t3_clear", 128'(arr_clear), 128'(1));
        check("t3_valid_drop", 128'(out_valid), 128'(0));
        step();
        check("t3_clear_off", 128'(arr_clear), 128'(0));
        wait_done("t3");

        // 4: wrap, 16*16*3 = 768 mod 256 = 0
        load(1'b0, fill(16));
        load(1'b1, fill(16));
        do_start(fill(0));
        wait_done("t4");

        // 5: start and a write during FEED are both ignored
        load(1'b0, id_m);
        load(1'b1, b_m);
        do_start(b_m);
        step();
        step();
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = '0;
        ld_col   = '0;
        ld_data  = 8'd99;
        check("t5_ld_ready", 128'(ld_ready), 128'(0));
        check("t5_busy", 128'(busy), 128'(1));
        step();
        start    = 1'b0;
        ld_valid = 1'b0;
        wait_done("t5");
        repeat (3) step();
        check("t5_idle_after", 128'(busy), 128'(0));

        // 6: reset at FEED t=2, then a fresh partial load
        load(1'b0, fill(2));
        load(1'b1, fill(3));
        do_start(fill(18));
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("t6_busy", 128'(busy), 128'(0));
        check("t6_arr_a", 128'(arr_a), 128'(0));
        check("t6_out_valid", 128'(out_valid), 128'(0));
        begin
            int dc;
            dc = done_cnt;
            step();
            reset = 1'b0;
            repeat (15) step();
            check("t6_no_done", 128'(done_cnt), 128'(dc));
        end
        wr(1'b0, 0, 0, 1);
        wr(1'b0, 0, 1, 2);
        wr(1'b0, 1, 1, 1);
        wr(1'b0, 2, 0, 3);
        wr(1'b0, 2, 2, 1);
        load(1'b1, b_m);
        do_start(c6_m);
        wait_done("t6");
        repeat (2) step();
        check("t6_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
